cr16_flag_stack: RTL

CR16_FLAG_STACK -- requirements
Module: cr16_flag_stack

---
 rtl/cr16_pkg.sv | 25 ++
 rtl/cr16_reg.sv | 16 +
 rtl/cr16_flag_stack.sv | 113 +++++++++++
 3 files changed

// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: flag bit positions, default flag width and
// the push/pop request decode used by the flag stack.
package cr16_pkg;

    localparam int CR16_FLAG_W = 5;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // Encoding is {pop, push}
    typedef enum logic [1:0] {
        STK_IDLE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_BOTH = 2'b11
    } stk_op_e;

    function automatic stk_op_e stk_decode(input logic push, input logic pop);
        return stk_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/cr16_reg.sv
// Generic register with asynchronous active-low clear.
module cr16_reg #(
    parameter int P_WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] d,
    output logic [P_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/cr16_flag_stack.sv
// Live CPU flag register with a small save/restore stack and sticky
// overflow/underflow error flags.
module cr16_flag_stack
    import cr16_pkg::*;
#(
    parameter int P_FLAG_WIDTH = CR16_FLAG_W,
    parameter int P_DEPTH      = 4
) (
    input  logic                         I_CLK,
    input  logic                         I_NRESET,
    input  logic                         I_ENABLE,
    input  logic [P_FLAG_WIDTH-1:0]      I_MASK,
    input  logic [P_FLAG_WIDTH-1:0]      I_FLAGS,
    input  logic                         I_PUSH,
    input  logic                         I_POP,
    input  logic                         I_CLEAR_ERR,
    output logic [P_FLAG_WIDTH-1:0]      O_FLAGS,
    output logic [$clog2(P_DEPTH+1)-1:0] O_DEPTH,
    output logic                         O_EMPTY,
    output logic                         O_FULL,
    output logic                         O_OVERFLOW,
    output logic                         O_UNDERFLOW
);

    localparam int DW = $clog2(P_DEPTH + 1);
    localparam int IW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    logic [P_FLAG_WIDTH-1:0] flags_q, flags_d;
    logic [P_FLAG_WIDTH-1:0] stack_q [P_DEPTH];
    logic [P_FLAG_WIDTH-1:0] stack_d [P_DEPTH];
    logic [DW-1:0]           depth_q, depth_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;

    logic          empty, full;
    logic          push_eff, pop_eff;
    logic          ovf_set, unf_set;
    logic [IW-1:0] wr_idx, rd_idx;
    stk_op_e       op;

    assign empty  = (depth_q == '0);
    assign full   = (depth_q == DW'(P_DEPTH));
    assign wr_idx = IW'(depth_q);
    assign rd_idx = IW'(depth_q - DW'(1));

    always_comb begin
        op       = stk_decode(I_PUSH, I_POP);
        push_eff = 1'b0;
        pop_eff  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        case (op)
            STK_PUSH: begin
                push_eff = !full;
                ovf_set  = full;
            end
            STK_POP: begin
                pop_eff = !empty;
                unf_set = empty;
            end
            default: ;
        endcase

        depth_d = depth_q;
        if (push_eff)     depth_d = depth_q + DW'(1);
        else if (pop_eff) depth_d = depth_q - DW'(1);

        // A restore overrides any concurrent ALU write
        flags_d = flags_q;
        if (pop_eff)       flags_d = stack_q[rd_idx];
        else if (I_ENABLE) flags_d = (flags_q & ~I_MASK) | (I_FLAGS & I_MASK);

        stack_d = stack_q;
        if (push_eff) stack_d[wr_idx] = flags_q;

        ovf_d = ovf_set | (ovf_q & ~I_CLEAR_ERR);
        unf_d = unf_set | (unf_q & ~I_CLEAR_ERR);
    end

    cr16_reg #(
        .P_WIDTH (P_FLAG_WIDTH)
    ) u_flags_reg (
        .clk   (I_CLK),
        .rst_n (I_NRESET),
        .d     (flags_d),
        .q     (flags_q)
    );

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is logically emptied by the depth reset; contents are kept
    always_ff @(posedge I_CLK) begin
        stack_q <= stack_d;
    end

    assign O_FLAGS     = flags_q;
    assign O_DEPTH     = depth_q;
    assign O_EMPTY     = empty;
    assign O_FULL      = full;
    assign O_OVERFLOW  = ovf_q;
    assign O_UNDERFLOW = unf_q;

endmodule
